dio_bus_sequencer: RTL and testbench
====================================

// Module: dio_bus_sequencer
// PURPOSE
//  Sequences register-file data/IO accesses onto the external memory/IO bus. Takes the
//  per-instruction read/write strobes plus data_address/IO_address from the register file,
//  stalls the pipeline via data_hazard until the bus acknowledges, and returns read data on
//  DIO_in. Serialises simultaneous data+IO requests (data first) and aborts hung accesses.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in ACCESS without bus_ack before abort (1..65535)
//  ABORT_RDATA     16'hFFFF  value returned on DIO_in for an aborted read
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  data_ren       in   1   instruction reads data space
//  data_wren      in   1   instruction writes data space
//  IO_ren         in   1   instruction reads IO space
//  IO_wren        in   1   instruction writes IO space
//  data_address   in   32  data-space address from reg file (already forwarded)
//  IO_address     in   16  IO-space address from reg file (already forwarded)
//  wr_data        in   16  store data
//  data_hazard    out  1   pipeline stall request to reg file / fetch
//  DIO_in         out  16  read data returned to reg file
//  bus_req        out  1   bus request, held until bus_ack
//  bus_we         out  1   1=write, 0=read
//  bus_io         out  1   1=IO space (addr[31:16]=0), 0=data space
//  bus_addr       out  32  access address
//  bus_wdata      out  16  write data
//  bus_ack        in   1   single-cycle completion strobe, valid only while bus_req=1
//  bus_rdata      in   16  read data, valid with bus_ack
//  timeout_err    out  1   sticky: an access was aborted; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, bus_req=0, bus_we=0, bus_io=0, bus_addr=0, bus_wdata=0, DIO_in=0,
//   timeout_err=0, pending IO flag=0, timeout counter=0; data_hazard=0 while rst_n=0.
//  any_req = data_ren|data_wren|IO_ren|IO_wren. ren and wren of same space never both set.
//  FSM states: IDLE, ACCESS, GAP, DONE.
//  IDLE: if any_req -> data_hazard=1 combinationally this cycle; latch first access
//   (data if data_* set, else IO), set pending_io if both spaces requested; bus_* regs
//   loaded, bus_req<=1; -> ACCESS. Else data_hazard=0.
//  ACCESS: data_hazard=1; bus_* stable; counter increments each cycle.
//   bus_ack: read -> DIO_in<=bus_rdata; bus_req<=0; counter<=0;
//     pending_io ? (load IO access, clear pending_io, -> GAP) : -> DONE.
//   counter==TIMEOUT_CYCLES-1 without ack: bus_req<=0, timeout_err<=1, read ->
//     DIO_in<=ABORT_RDATA; pending_io dropped; -> DONE.
//  GAP: data_hazard=1, bus_req=0 for exactly one cycle (bus turnaround); bus_req<=1 -> ACCESS.
//  DONE: data_hazard=0, strobes ignored for this cycle (stalled instruction advances); -> IDLE.
//  DIO_in holds its value from DONE until the next read completes (reg file samples it
//   the cycle after DONE).
//  Latency: single access, ack in first ACCESS cycle -> data_hazard high 2 cycles.
//   Dual access, both acks immediate -> 4 cycles (IDLE,ACCESS,GAP,ACCESS).
//  Dual read (data_ren & IO_ren): DIO_in ends with IO value; data value is discarded.
//  bus_ack outside ACCESS is ignored. bus_io=1 forces bus_addr[31:16]=0.
//  Reset asserted mid-access: bus_req drops asynchronously, no completion, DIO_in=0.
// STRUCTURE
//  Shared package: state enum {IDLE,ACCESS,GAP,DONE}, bus_cmd struct {we,io,addr,wdata}.
//  One natural sub-module: dio_timeout_ctr (clear/enable counter, terminal-count output).
//  Remainder (FSM, request latch, DIO_in capture) stays in this module.
// TESTING
//  1 data_ren, addr 0x0001_2340, ack after 3 cycles w/ rdata 0xBEEF -> bus_io=0, hazard 5 cyc,
//    DIO_in=0xBEEF from DONE on, bus_req low cycle after ack.
//  2 IO_wren, IO_address 0x00A5, wr_data 0x1234, immediate ack -> bus_addr=0x0000_00A5,
//    bus_we=1, bus_io=1, hazard exactly 2 cycles, DIO_in unchanged.
//  3 data_wren + IO_ren same cycle, immediate acks, IO rdata 0x0042 -> data write first,
//    one GAP cycle with bus_req=0, then IO read; hazard 4 cycles; DIO_in=0x0042.
//  4 data_ren, TIMEOUT_CYCLES=8, no ack -> bus_req drops after 8 ACCESS cycles,
//    timeout_err=1 sticky, DIO_in=0xFFFF, next access proceeds normally.
//  5 rst_n low during ACCESS then release -> bus_req=0 immediately, state IDLE,
//    DIO_in=0, timeout_err=0; pending strobe re-launches cleanly after reset.
//  6 strobes held high through DONE -> no relaunch in DONE; new access starts only
//    when strobes present in IDLE; spurious bus_ack in IDLE has no effect.

Source files
------------

// File: rtl/dio_bus_sequencer_pkg.sv
// Shared types for the data/IO bus sequencer: FSM state encoding and the latched bus command.
package dio_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic        we;
    logic        io;
    logic [31:0] addr;
    logic [15:0] wdata;
  } bus_cmd_t;

  // IO space occupies the low 64K, so the upper address half is forced to zero.
  function automatic bus_cmd_t make_io_cmd(input logic we, input logic [15:0] io_address,
                                           input logic [15:0] wdata);
    bus_cmd_t cmd;
    cmd.we    = we;
    cmd.io    = 1'b1;
    cmd.addr  = {16'h0000, io_address};
    cmd.wdata = wdata;
    return cmd;
  endfunction

  function automatic bus_cmd_t make_data_cmd(input logic we, input logic [31:0] data_address,
                                             input logic [15:0] wdata);
    bus_cmd_t cmd;
    cmd.we    = we;
    cmd.io    = 1'b0;
    cmd.addr  = data_address;
    cmd.wdata = wdata;
    return cmd;
  endfunction

endpackage

// File: rtl/dio_bus_sequencer_timeout_ctr.sv
// Access watchdog: counts cycles while enabled and flags the last permitted cycle.
module dio_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [15:0] TERMINAL_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_r;

  // Cycle counter with clear taking priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (enable) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = enable & (count_r == TERMINAL_COUNT);

endmodule

// File: rtl/dio_bus_sequencer.sv
// Sequences data/IO register-file accesses onto the external bus, stalling the pipeline until
// each access completes; a dual data+IO request is split into data first, then IO.
module dio_bus_sequencer
  import dio_bus_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] ABORT_RDATA    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_ren,
  input  logic        data_wren,
  input  logic        IO_ren,
  input  logic        IO_wren,
  input  logic [31:0] data_address,
  input  logic [15:0] IO_address,
  input  logic [15:0] wr_data,
  output logic        data_hazard,
  output logic [15:0] DIO_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [31:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        timeout_err
);

  state_t      state_r;
  state_t      state_next_s;
  bus_cmd_t    cmd_r;
  bus_cmd_t    pend_cmd_r;
  bus_cmd_t    data_cmd_s;
  bus_cmd_t    io_cmd_s;
  logic        pending_io_r;
  logic        bus_req_r;
  logic [15:0] dio_in_r;
  logic        timeout_err_r;
  logic        data_req_s;
  logic        io_req_s;
  logic        any_req_s;
  logic        hazard_s;
  logic        in_access_s;
  logic        terminal_s;

  assign data_req_s  = data_ren | data_wren;
  assign io_req_s    = IO_ren | IO_wren;
  assign any_req_s   = data_req_s | io_req_s;
  assign data_cmd_s  = make_data_cmd(data_wren, data_address, wr_data);
  assign io_cmd_s    = make_io_cmd(IO_wren, IO_address, wr_data);
  assign in_access_s = (state_r == ACCESS);

  dio_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (~in_access_s | bus_ack),
    .enable   (in_access_s),
    .terminal (terminal_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and stall decode; DONE deliberately ignores strobes so the stalled instruction retires.
  always_comb begin
    state_next_s = state_r;
    hazard_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          hazard_s     = 1'b1;
          state_next_s = ACCESS;
        end else begin
          hazard_s     = 1'b0;
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        hazard_s = 1'b1;
        if (bus_ack) begin
          state_next_s = pending_io_r ? GAP : DONE;
        end else if (terminal_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACCESS;
        end
      end
      GAP: begin
        hazard_s     = 1'b1;
        state_next_s = ACCESS;
      end
      DONE: begin
        hazard_s     = 1'b0;
        state_next_s = IDLE;
      end
      default: begin
        hazard_s     = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // Request latch, bus command registers and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r         <= '0;
      pend_cmd_r    <= '0;
      pending_io_r  <= 1'b0;
      bus_req_r     <= 1'b0;
      dio_in_r      <= 16'h0000;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            cmd_r        <= data_req_s ? data_cmd_s : io_cmd_s;
            pend_cmd_r   <= io_cmd_s;
            pending_io_r <= data_req_s & io_req_s;
            bus_req_r    <= 1'b1;
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            bus_req_r <= 1'b0;
            if (!cmd_r.we) begin
              dio_in_r <= bus_rdata;
            end
            if (pending_io_r) begin
              cmd_r        <= pend_cmd_r;
              pending_io_r <= 1'b0;
            end
          end else if (terminal_s) begin
            // A hung access also drops any queued IO half of a dual request.
            bus_req_r     <= 1'b0;
            timeout_err_r <= 1'b1;
            pending_io_r  <= 1'b0;
            if (!cmd_r.we) begin
              dio_in_r <= ABORT_RDATA;
            end
          end
        end
        GAP: begin
          bus_req_r <= 1'b1;
        end
        DONE: begin
          bus_req_r <= 1'b0;
        end
        default: begin
          bus_req_r    <= 1'b0;
          pending_io_r <= 1'b0;
        end
      endcase
    end
  end

  assign data_hazard = hazard_s & rst_n;
  assign DIO_in      = dio_in_r;
  assign bus_req     = bus_req_r;
  assign bus_we      = cmd_r.we;
  assign bus_io      = cmd_r.io;
  assign bus_addr    = cmd_r.addr;
  assign bus_wdata   = cmd_r.wdata;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_dio_bus_sequencer.sv
// Scoreboard bench: stimulus pushes expected bus commands and completion results; monitors
// pop and compare when the DUT raises bus_req or releases data_hazard.
module tb_dio_bus_sequencer;
  import dio_bus_sequencer_pkg::*;

  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [31:0] hz;
    logic [15:0] dio;
    logic        terr;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_ren = 1'b0, data_wren = 1'b0, IO_ren = 1'b0, IO_wren = 1'b0;
  logic [31:0] data_address = 32'h0;
  logic [15:0] IO_address = 16'h0, wr_data = 16'h0;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = 16'h0;
  logic        data_hazard, bus_req, bus_we, bus_io, timeout_err;
  logic [15:0] DIO_in, bus_wdata;
  logic [31:0] bus_addr;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int resp_cnt = 0;
  int resp_delay = 0;
  bit resp_en = 1'b0;
  bit spurious_ack = 1'b0;
  logic [15:0] data_rdata_v = 16'h0, io_rdata_v = 16'h0;
  bus_cmd_t exp_bus_q[$];
  res_t     exp_res_q[$];

  dio_bus_sequencer #(.TIMEOUT_CYCLES(TO), .ABORT_RDATA(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .data_ren(data_ren), .data_wren(data_wren),
    .IO_ren(IO_ren), .IO_wren(IO_wren), .data_address(data_address),
    .IO_address(IO_address), .wr_data(wr_data), .data_hazard(data_hazard),
    .DIO_in(DIO_in), .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bus_cmd_t ecmd(input logic we, input logic io, input logic [31:0] addr,
                                    input logic [15:0] wdata);
    bus_cmd_t c;
    c.we = we; c.io = io; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  function automatic res_t eres(input int hz, input logic [15:0] dio, input logic terr);
    res_t r;
    r.hz = hz; r.dio = dio; r.terr = terr;
    return r;
  endfunction

  // Bus responder: acks after resp_delay waiting cycles, plus one-shot spurious acks.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      if (bus_req && resp_en) begin
        if (resp_cnt == resp_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = bus_io ? io_rdata_v : data_rdata_v;
          resp_cnt  = 0;
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
        if (spurious_ack) begin
          bus_ack      = 1'b1;
          bus_rdata    = 16'hDEAD;
          spurious_ack = 1'b0;
        end
      end
    end
  end

  // Bus monitor: each new bus_req assertion must match the next expected command.
  initial begin
    bus_cmd_t e;
    logic prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req && !prev_req) begin
        if (exp_bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus_req: got addr 0x%0h expected no access", bus_addr);
        end else begin
          e = exp_bus_q.pop_front();
          check("bus_we", {31'h0, bus_we}, {31'h0, e.we});
          check("bus_io", {31'h0, bus_io}, {31'h0, e.io});
          check("bus_addr", bus_addr, e.addr);
          if (e.we) check("bus_wdata", {16'h0, bus_wdata}, {16'h0, e.wdata});
        end
      end
      prev_req = bus_req;
    end
  end

  // Completion monitor: hazard length and DONE-cycle outputs.
  initial begin
    res_t e;
    int hz = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hz = 0;
      end else if (data_hazard) begin
        hz++;
      end else if (hz > 0) begin
        if (exp_res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got hazard %0d cycles expected none", hz);
        end else begin
          e = exp_res_q.pop_front();
          check("hazard_cycles", hz, e.hz);
          check("dio_in", {16'h0, DIO_in}, {16'h0, e.dio});
          check("timeout_err", {31'h0, timeout_err}, {31'h0, e.terr});
          check("bus_req_done", {31'h0, bus_req}, 32'h0);
        end
        hz = 0;
        done_cnt++;
      end
    end
  end

  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int i = 0; i < 100 && done_cnt == start; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no completion expected one within 100 cycles");
    end
  endtask

  task automatic clear_strobes();
    data_ren = 1'b0; data_wren = 1'b0; IO_ren = 1'b0; IO_wren = 1'b0;
  endtask

  // Strobes stay high through DONE and drop at the start of the following IDLE cycle.
  task automatic issue(input logic dr, input logic dw, input logic ir, input logic iw,
                       input logic [31:0] daddr, input logic [15:0] ioaddr, input logic [15:0] wd);
    @(posedge clk);
    #1;
    data_ren = dr; data_wren = dw; IO_ren = ir; IO_wren = iw;
    data_address = daddr; IO_address = ioaddr; wr_data = wd;
    wait_done();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    data_ren = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hazard", {31'h0, data_hazard}, 32'h0);
    check("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("rst_bus_we", {31'h0, bus_we}, 32'h0);
    check("rst_bus_io", {31'h0, bus_io}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", {16'h0, bus_wdata}, 32'h0);
    check("rst_dio_in", {16'h0, DIO_in}, 32'h0);
    check("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
    data_ren = 1'b0;
    rst_n = 1'b1;

    // data read, ack after 3 waiting cycles
    resp_en = 1'b1; resp_delay = 3; data_rdata_v = 16'hBEEF;
    exp_bus_q.push_back(ecmd(1'b0, 1'b0, 32'h0001_2340, 16'h0));
    exp_res_q.push_back(eres(5, 16'hBEEF, 1'b0));
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0001_2340, 16'h0000, 16'h0000);

    // IO write, immediate ack; upper address from data space must not leak
    resp_delay = 0;
    exp_bus_q.push_back(ecmd(1'b1, 1'b1, 32'h0000_00A5, 16'h1234));
    exp_res_q.push_back(eres(2, 16'hBEEF, 1'b0));
    issue(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 16'h00A5, 16'h1234);

    // data write + IO read
    io_rdata_v = 16'h0042;
    exp_bus_q.push_back(ecmd(1'b1, 1'b0, 32'h0000_1000, 16'h7777));
    exp_bus_q.push_back(ecmd(1'b0, 1'b1, 32'h0000_0033, 16'h7777));
    exp_res_q.push_back(eres(4, 16'h0042, 1'b0));
    issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 16'h0033, 16'h7777);

    // dual read: IO value wins
    data_rdata_v = 16'h1111; io_rdata_v = 16'h2222;
    exp_bus_q.push_back(ecmd(1'b0, 1'b0, 32'h00AB_0000, 16'h0));
    exp_bus_q.push_back(ecmd(1'b0, 1'b1, 32'h0000_BEEF, 16'h0));
    exp_res_q.push_back(eres(4, 16'h2222, 1'b0));
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h00AB_0000, 16'hBEEF, 16'h0000);

    // timeout on a read, then a normal IO read with the sticky error kept
    resp_en = 1'b0;
    exp_bus_q.push_back(ecmd(1'b0, 1'b0, 32'h0000_8000, 16'h0));
    exp_res_q.push_back(eres(1 + TO, 16'hFFFF, 1'b1));
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_8000, 16'h0000, 16'h0000);
    resp_en = 1'b1; io_rdata_v = 16'h5A5A;
    exp_bus_q.push_back(ecmd(1'b0, 1'b1, 32'h0000_0010, 16'h0));
    exp_res_q.push_back(eres(2, 16'h5A5A, 1'b1));
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 16'h0010, 16'h0000);

    // reset mid-access, strobe held across reset relaunches afterwards
    resp_en = 1'b0;
    exp_bus_q.push_back(ecmd(1'b0, 1'b0, 32'h0000_4444, 16'h0));
    @(posedge clk);
    #1;
    data_ren = 1'b1; data_address = 32'h0000_4444;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus_req", {31'h0, bus_req}, 32'h0);
    check("mid_rst_dio_in", {16'h0, DIO_in}, 32'h0);
    check("mid_rst_timeout_err", {31'h0, timeout_err}, 32'h0);
    check("mid_rst_hazard", {31'h0, data_hazard}, 32'h0);
    @(posedge clk);
    #1;
    resp_en = 1'b1; data_rdata_v = 16'h1357;
    exp_bus_q.push_back(ecmd(1'b0, 1'b0, 32'h0000_4444, 16'h0));
    exp_res_q.push_back(eres(2, 16'h1357, 1'b0));
    rst_n = 1'b1;
    wait_done();
    @(posedge clk);
    #1;
    clear_strobes();

    // spurious ack while idle must change nothing
    spurious_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("spurious_dio_in", {16'h0, DIO_in}, 32'h0000_1357);
    check("spurious_bus_req", {31'h0, bus_req}, 32'h0);
    check("spurious_hazard", {31'h0, data_hazard}, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check("bus_q_drained", exp_bus_q.size(), 32'h0);
    check("res_q_drained", exp_res_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
